// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch -> issue instruction buffer.
//   IFQ_DEPTH : default queue depth used at the top level
//   pipe_in_t : packet handed from fetch to issue (pc, instruction, prediction)
package fetch_queue_pkg;

  localparam int IFQ_DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred_taken;
    logic [31:0] pred_target;
  } pipe_in_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry circular FIFO between fetch and issue.
// Lets fetch run ahead while issue stalls; flush squashes every entry in
// one cycle.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   flush        squash all entries (wins over enqueue and dequeue)
//   enq_valid    fetch presents enq_data
//   enq_data     packet to store
//   enq_ready    queue not full (registered state only)
//   deq_valid    head entry valid
//   deq_data     head packet (flop-array read on registered head)
//   deq_yumi     issue consumes head this cycle
//   count        occupancy
//   almost_full  count >= ALMOST_FULL
//   empty        count == 0
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH       = IFQ_DEPTH,
  parameter int ALMOST_FULL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       enq_valid,
  input  pipe_in_t                   enq_data,
  output logic                       enq_ready,
  output logic                       deq_valid,
  output pipe_in_t                   deq_data,
  input  logic                       deq_yumi,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  pipe_in_t        mem_q [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            enq_fire, deq_fire;

  // Status is derived from count_q alone; no path from deq_yumi/flush to
  // enq_ready, and a full queue never accepts even if it drains this cycle.
  assign enq_ready   = (count_q != CW'(DEPTH));
  assign deq_valid   = (count_q != '0);
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= CW'(ALMOST_FULL));
  assign count       = count_q;
  assign deq_data    = mem_q[head_q];

  // A yumi without deq_valid is ignored rather than trusted.
  assign enq_fire = enq_valid & enq_ready & ~flush;
  assign deq_fire = deq_yumi  & deq_valid & ~flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Pointers are power-of-two wide, so +1 wraps for free.
      if (enq_fire) tail_d = tail_q + PW'(1);
      if (deq_fire) head_d = head_q + PW'(1);
      count_d = count_q + CW'(enq_fire) - CW'(deq_fire);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is intentionally not reset; deq_valid qualifies it.
  always_ff @(posedge clk) begin
    if (enq_fire) mem_q[tail_q] <= enq_data;
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int AF    = DEPTH - 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush, enq_valid, deq_yumi;
  pipe_in_t   enq_data;
  logic       enq_ready, deq_valid, almost_full, empty;
  pipe_in_t   deq_data;
  logic [3:0] count;

  int total = 0;
  int bad   = 0;

  pipe_in_t mq[$];  // reference model: queue of packets in order

  fetch_queue #(.DEPTH(DEPTH), .ALMOST_FULL(AF)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .enq_valid(enq_valid), .enq_data(enq_data), .enq_ready(enq_ready),
    .deq_valid(deq_valid), .deq_data(deq_data), .deq_yumi(deq_yumi),
    .count(count), .almost_full(almost_full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Stimulus must never present yumi with an empty queue.
  always @(posedge clk) begin
    if (reset && deq_yumi && !deq_valid) begin
      bad++;
      $display("FAIL illegal_yumi at %0t: deq_yumi=1 deq_valid=0", $time);
    end
  end

  function automatic pipe_in_t mk(input logic [31:0] pc);
    pipe_in_t p;
    p.pc          = pc;
    p.instr       = pc ^ 32'hA5A5_0000;
    p.pred_taken  = pc[2];
    p.pred_target = pc + 32'd8;
    return p;
  endfunction

  // Drives one cycle, advances the reference model by the queue's rules,
  // and leaves time at posedge+1 for sampling. No comparisons here.
  task automatic drive_cycle(input logic ev, input logic [31:0] pc,
                             input logic y, input logic fl);
    pipe_in_t p;
    bit ef, df;
    p = mk(pc);
    enq_valid = ev; enq_data = p; deq_yumi = y; flush = fl;
    ef = ev && (mq.size() < DEPTH) && !fl;
    df = y && (mq.size() > 0) && !fl;
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (df) void'(mq.pop_front());
      if (ef) mq.push_back(p);
    end
    #1;
    enq_valid = 1'b0; deq_yumi = 1'b0; flush = 1'b0;
  endtask

  task automatic drain;
    int guard = 0;
    while (mq.size() > 0 && guard < 4 * DEPTH) begin
      total++;
      if (deq_data !== mq[0]) begin
        bad++;
        $display("FAIL drain_data: got pc=%h want pc=%h", deq_data.pc, mq[0].pc);
      end
      drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
      guard++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; flush = 1'b0; enq_valid = 1'b0; deq_yumi = 1'b0;
    enq_data = mk(32'h0);
    #12;
    total++;
    if ({count, deq_valid, empty, enq_ready, almost_full} !== {4'd0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: cnt=%0d dv=%b em=%b rdy=%b af=%b", count, deq_valid, empty, enq_ready, almost_full);
    end
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) drive_cycle(1'b1, 32'(i * 4), 1'b0, 1'b0);
    total++;
    if (count !== 4'd3) begin bad++; $display("FAIL pre_reset_count: got %0d want 3", count); end
    // Asynchronous reset mid-cycle, away from any clock edge.
    reset = 1'b0;
    #2;
    total++;
    if ({count, deq_valid, enq_ready} !== {4'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL async_reset: cnt=%0d dv=%b rdy=%b want 0/0/1", count, deq_valid, enq_ready);
    end
    mq.delete();
    reset = 1'b1;
    drive_cycle(1'b1, 32'h10, 1'b0, 1'b0);
    total++;
    if (deq_valid !== 1'b1 || deq_data.pc !== 32'h10 || count !== 4'd1) begin
      bad++;
      $display("FAIL post_reset_enq: dv=%b pc=%h cnt=%0d want 1/10/1", deq_valid, deq_data.pc, count);
    end
    drain();
  endtask

  task automatic test_fill;
    for (int i = 0; i < DEPTH; i++) begin
      drive_cycle(1'b1, 32'(i * 4), 1'b0, 1'b0);
      total++;
      if (count !== 4'(i + 1) || almost_full !== ((i + 1) >= AF)) begin
        bad++;
        $display("FAIL fill_step%0d: cnt=%0d af=%b want %0d/%b", i, count, almost_full, i + 1, (i + 1) >= AF);
      end
    end
    drive_cycle(1'b1, 32'h20, 1'b0, 1'b0);
    total++;
    if (count !== 4'd8 || enq_ready !== 1'b0 || deq_data.pc !== 32'h0) begin
      bad++;
      $display("FAIL full_reject: cnt=%0d rdy=%b pc=%h want 8/0/0", count, enq_ready, deq_data.pc);
    end
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (deq_data.pc !== 32'(i * 4)) begin
        bad++;
        $display("FAIL fill_order%0d: got pc=%h want %h", i, deq_data.pc, i * 4);
      end
      drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
    end
    total++;
    if (empty !== 1'b1 || deq_valid !== 1'b0) begin
      bad++;
      $display("FAIL fill_drained: em=%b dv=%b want 1/0", empty, deq_valid);
    end
  endtask

  task automatic test_full_enq_deq;
    for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 32'h40 + 32'(i * 4), 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h80, 1'b1, 1'b0);
    total++;
    if (count !== 4'd7 || deq_data.pc !== 32'h44) begin
      bad++;
      $display("FAIL full_both: cnt=%0d pc=%h want 7/44", count, deq_data.pc);
    end
    drive_cycle(1'b1, 32'h80, 1'b0, 1'b0);
    total++;
    if (count !== 4'd8 || enq_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_retry: cnt=%0d rdy=%b want 8/0", count, enq_ready);
    end
    drain();
  endtask

  task automatic test_back_to_back;
    logic [31:0] next_pc = 32'h200;
    logic [31:0] head_pc = 32'h200;
    for (int i = 0; i < 3; i++) begin drive_cycle(1'b1, next_pc, 1'b0, 1'b0); next_pc += 4; end
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b1, next_pc, 1'b1, 1'b0);
      next_pc += 4; head_pc += 4;
      total++;
      if (count !== 4'd3 || deq_data.pc !== head_pc) begin
        bad++;
        $display("FAIL stream%0d: cnt=%0d pc=%h want 3/%h", i, count, deq_data.pc, head_pc);
      end
    end
    drain();
  endtask

  task automatic test_flush;
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 32'h300 + 32'(i * 4), 1'b0, 1'b0);
    drive_cycle(1'b1, 32'hBEEF0, 1'b1, 1'b1);
    total++;
    if (count !== 4'd0 || deq_valid !== 1'b0 || empty !== 1'b1) begin
      bad++;
      $display("FAIL flush_clear: cnt=%0d dv=%b em=%b want 0/0/1", count, deq_valid, empty);
    end
    drive_cycle(1'b1, 32'h100, 1'b0, 1'b0);
    total++;
    if (count !== 4'd1 || deq_valid !== 1'b1 || deq_data.pc !== 32'h100) begin
      bad++;
      $display("FAIL flush_after: cnt=%0d dv=%b pc=%h want 1/1/100", count, deq_valid, deq_data.pc);
    end
    drain();
  endtask

  task automatic test_random;
    logic [31:0] pc = 32'h1000;
    int errs = 0;
    for (int c = 0; c < 10000; c++) begin
      logic ev, y, fl;
      ev = ($urandom % 4) != 0;
      y  = (mq.size() > 0) && (($urandom % 3) != 0);
      fl = ($urandom % 64) == 0;
      drive_cycle(ev, pc, y, fl);
      if (ev) pc += 4;
      total++;
      if (count !== 4'(mq.size()) || deq_valid !== (mq.size() > 0) ||
          enq_ready !== (mq.size() < DEPTH) || almost_full !== (mq.size() >= AF) ||
          empty !== (mq.size() == 0) || (mq.size() > 0 && deq_data !== mq[0])) begin
        bad++;
        if (errs < 10)
          $display("FAIL random_c%0d: cnt=%0d want %0d dv=%b rdy=%b af=%b pc=%h want %h",
                   c, count, mq.size(), deq_valid, enq_ready, almost_full, deq_data.pc,
                   (mq.size() > 0) ? mq[0].pc : 32'h0);
        errs++;
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_enq_deq();
    test_back_to_back();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
